// File: rtl/ml_pkg.sv
// Shared types and helpers for the ML layer sequencer: FSM state encoding,
// address-width sizing and a width-generic signed saturation.
package ml_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    MAC,
    FLUSH,
    WRITE,
    DONE
  } state_t;

  localparam int SAT_W = 64;

  // A memory of depth 1 still needs a one-bit address port.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] val,
                                                       input int width);
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (val > max_v) return max_v;
    if (val < min_v) return min_v;
    return val;
  endfunction

endpackage

// File: rtl/ml_mac.sv
// Shared multiply-accumulate datapath: bias load, signed accumulate, shift and saturate.
// Optional ReLU on the output when ML_RELU_EN is defined.
module ml_mac
  import ml_pkg::*;
#(
  parameter int pDATA_W = 8,
  parameter int pACC_W  = 20,
  parameter int pSHIFT  = 0
) (
  input  logic               usb_clk,
  input  logic               rst,
  input  logic               load_bias,
  input  logic               accumulate,
  input  logic [pDATA_W-1:0] b_data,
  input  logic [pDATA_W-1:0] in_data,
  input  logic [pDATA_W-1:0] w_data,
  output logic [pDATA_W-1:0] result
);

  logic signed [2*pDATA_W-1:0] product;
  logic signed [pACC_W-1:0]    acc;
  logic signed [pACC_W-1:0]    shifted;
  logic signed [SAT_W-1:0]     wide;
  logic signed [SAT_W-1:0]     sat;

  // Operands are sign-extended first so the low half of the product is the exact signed product.
  assign product = $signed({{pDATA_W{in_data[pDATA_W-1]}}, in_data}) *
                   $signed({{pDATA_W{w_data[pDATA_W-1]}}, w_data});

  always_ff @(posedge usb_clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (load_bias) begin
      acc <= {{(pACC_W-pDATA_W){b_data[pDATA_W-1]}}, b_data};
    end else if (accumulate) begin
      acc <= acc + {{(pACC_W-2*pDATA_W){product[2*pDATA_W-1]}}, product};
    end
  end

  assign shifted = acc >>> pSHIFT;
  assign wide    = {{(SAT_W-pACC_W){shifted[pACC_W-1]}}, shifted};
  assign sat     = saturate(wide, pDATA_W);

`ifdef ML_RELU_EN
  assign result = shifted[pACC_W-1] ? '0 : pDATA_W'(sat);
`else
  assign result = pDATA_W'(sat);
`endif

endmodule

// File: rtl/ml_layer_sequencer.sv
// Sequences one fully-connected layer over the shared ml_mac datapath and writes
// one saturated result per output neuron. Output ReLU selected by ML_RELU_EN.
module ml_layer_sequencer
  import ml_pkg::*;
#(
  parameter int pINPUTCNT  = 4,
  parameter int pOUTPUTCNT = 4,
  parameter int pDATA_W    = 8,
  parameter int pACC_W     = 20,
  parameter int pSHIFT     = 0,
  localparam int IN_AW     = addr_w(pINPUTCNT),
  localparam int W_AW      = addr_w(pINPUTCNT * pOUTPUTCNT),
  localparam int OUT_AW    = addr_w(pOUTPUTCNT)
) (
  input  logic               usb_clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               trigger,
  output logic [IN_AW-1:0]   in_addr,
  input  logic [pDATA_W-1:0] in_data,
  output logic [W_AW-1:0]    w_addr,
  input  logic [pDATA_W-1:0] w_data,
  output logic [OUT_AW-1:0]  b_addr,
  input  logic [pDATA_W-1:0] b_data,
  output logic               res_we,
  output logic [OUT_AW-1:0]  res_addr,
  output logic [pDATA_W-1:0] res_data
);

  state_t            state;
  logic [IN_AW-1:0]  i;
  logic [OUT_AW-1:0] o;
  logic              we_q;
  logic              load_bias;
  logic              accumulate;
  logic [W_AW-1:0]   w_base;

  // Read data lags its address by one cycle, so the MAC datapath works one index behind.
  assign load_bias  = (state == MAC) && (i == '0);
  assign accumulate = ((state == MAC) && (i != '0)) || (state == FLUSH);
  assign w_base     = W_AW'(o) * W_AW'(pINPUTCNT);
  assign res_we     = we_q & ~abort;
  assign trigger    = busy;

  always_ff @(posedge usb_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      we_q     <= 1'b0;
      i        <= '0;
      o        <= '0;
      in_addr  <= '0;
      w_addr   <= '0;
      b_addr   <= '0;
      res_addr <= '0;
    end else if (abort && (state inside {BIAS, MAC, FLUSH, WRITE})) begin
      state <= IDLE;
      busy  <= 1'b0;
      we_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            state  <= BIAS;
            busy   <= 1'b1;
            o      <= '0;
            b_addr <= '0;
          end
        end
        BIAS: begin
          state   <= MAC;
          i       <= '0;
          in_addr <= '0;
          w_addr  <= w_base;
        end
        MAC: begin
          if (i == IN_AW'(pINPUTCNT - 1)) begin
            state <= FLUSH;
          end else begin
            i       <= i + IN_AW'(1);
            in_addr <= i + IN_AW'(1);
            w_addr  <= w_base + W_AW'(i) + W_AW'(1);
          end
        end
        FLUSH: begin
          state    <= WRITE;
          we_q     <= 1'b1;
          res_addr <= o;
        end
        WRITE: begin
          we_q <= 1'b0;
          if (o == OUT_AW'(pOUTPUTCNT - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state  <= BIAS;
            o      <= o + OUT_AW'(1);
            b_addr <= o + OUT_AW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  ml_mac #(
    .pDATA_W(pDATA_W),
    .pACC_W (pACC_W),
    .pSHIFT (pSHIFT)
  ) u_mac (
    .usb_clk   (usb_clk),
    .rst       (rst),
    .load_bias (load_bias),
    .accumulate(accumulate),
    .b_data    (b_data),
    .in_data   (in_data),
    .w_data    (w_data),
    .result    (res_data)
  );

endmodule

// File: tb/tb_ml_layer_sequencer.sv
// Directed self-checking bench for ml_layer_sequencer with behavioural synchronous memories.
// Expected results follow ML_RELU_EN when the bench is built with it.
module tb_ml_layer_sequencer;

  logic       usb_clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic       trigger;
  logic [1:0] in_addr;
  logic [7:0] in_data;
  logic [3:0] w_addr;
  logic [7:0] w_data;
  logic [1:0] b_addr;
  logic [7:0] b_data;
  logic       res_we;
  logic [1:0] res_addr;
  logic [7:0] res_data;

  logic [7:0] in_mem [4];
  logic [7:0] w_mem  [16];
  logic [7:0] b_mem  [4];

  int errors = 0;
  int checks = 0;
  int wr_addr_q [$];
  int wr_data_q [$];
  int done_cnt = 0;
  int trig_cnt = 0;
  int edges;

  ml_layer_sequencer dut (
    .usb_clk (usb_clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .trigger (trigger),
    .in_addr (in_addr),
    .in_data (in_data),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .res_we  (res_we),
    .res_addr(res_addr),
    .res_data(res_data)
  );

  always #5 usb_clk = ~usb_clk;

  // Synchronous-read memories: data appears one cycle after the address.
  always @(posedge usb_clk) begin
    in_data <= in_mem[in_addr];
    w_data  <= w_mem[w_addr];
    b_data  <= b_mem[b_addr];
  end

  always @(negedge usb_clk) begin
    if (res_we) begin
      wr_addr_q.push_back(int'(res_addr));
      wr_data_q.push_back(int'(res_data));
    end
    if (done) done_cnt++;
    if (trigger) trig_cnt++;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_trigger"}, int'(trigger), 0);
    checkOutput({tag, "_res_we"}, int'(res_we), 0);
    checkOutput({tag, "_addrs"}, int'({in_addr, w_addr, b_addr, res_addr}), 0);
    checkOutput({tag, "_res_data"}, int'(res_data), 0);
  endtask

  task automatic checkWrites(input string tag, input int count, input int exp_data [4]);
    checkOutput({tag, "_wr_count"}, wr_data_q.size(), count);
    for (int k = 0; k < wr_data_q.size() && k < count; k++) begin
      checkOutput($sformatf("%s_wr%0d_addr", tag, k), wr_addr_q[k], k);
      checkOutput($sformatf("%s_wr%0d_data", tag, k), wr_data_q[k], exp_data[k]);
    end
  endtask

  task automatic clearLogs();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
    trig_cnt = 0;
  endtask

  task automatic loadUniform(input logic [7:0] iv, input logic [7:0] wv, input logic [7:0] bv);
    for (int k = 0; k < 4; k++) begin
      in_mem[k] = iv;
      b_mem[k]  = bv;
    end
    for (int k = 0; k < 16; k++) w_mem[k] = wv;
  endtask

  // Starts a run; pulses start/abort after the given edge numbers; stops on done or budget.
  task automatic applyStimulus(input int pulse_a, input int pulse_b, input int abort_at,
                               input int max_edges, output int seen_edges);
    int n;
    n          = 0;
    seen_edges = 0;
    start      = 1'b1;
    abort      = 1'b0;
    @(posedge usb_clk);
    #1;
    start = 1'b0;
    while (n < max_edges) begin
      @(posedge usb_clk);
      #1;
      n++;
      start = (n == pulse_a) || (n == pulse_b);
      abort = (n == abort_at);
      if (done) begin
        seen_edges = n;
        break;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge usb_clk);
    #1;
  endtask

  initial begin
    int exp_ones [4];
    int exp_pos [4];
    int exp_neg [4];
    int exp_mix [4];
    int exp_bias [4];
    int none [4];
    exp_ones = '{8, 8, 8, 8};
    exp_pos  = '{127, 127, 127, 127};
    none     = '{0, 0, 0, 0};
`ifdef ML_RELU_EN
    exp_neg  = '{0, 0, 0, 0};
    exp_bias = '{0, 0, 0, 0};
    exp_mix  = '{6, 8, 0, 4};
`else
    exp_neg  = '{128, 128, 128, 128};
    exp_bias = '{246, 246, 246, 246};
    exp_mix  = '{6, 8, 249, 4};
`endif

    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    loadUniform(8'd1, 8'd2, 8'd0);
    repeat (2) @(posedge usb_clk);
    #1;
    checkIdleOutputs("reset");
    rst = 1'b0;
    idleCycle();

    $display("[TB] basic run: inputs 1, weights 2, bias 0");
    clearLogs();
    applyStimulus(-1, -1, -1, 100, edges);
    idleCycle();
    checkOutput("basic_done_edge", edges, 28);
    checkOutput("basic_trigger_cycles", trig_cnt, 28);
    checkOutput("basic_done_pulses", done_cnt, 1);
    checkOutput("basic_busy_after", int'(busy), 0);
    checkWrites("basic", 4, exp_ones);

    $display("[TB] positive saturation");
    loadUniform(8'd127, 8'd127, 8'd0);
    clearLogs();
    applyStimulus(-1, -1, -1, 100, edges);
    idleCycle();
    checkOutput("satpos_done_edge", edges, 28);
    checkWrites("satpos", 4, exp_pos);

    $display("[TB] negative saturation");
    loadUniform(8'd127, 8'h80, 8'd0);
    clearLogs();
    applyStimulus(-1, -1, -1, 100, edges);
    idleCycle();
    checkWrites("satneg", 4, exp_neg);

    $display("[TB] negative result with bias");
    loadUniform(8'd1, 8'hFD, 8'd2);
    clearLogs();
    applyStimulus(-1, -1, -1, 100, edges);
    idleCycle();
    checkWrites("bias", 4, exp_bias);

    $display("[TB] per-neuron vectors");
    in_mem = '{8'd1, 8'hFE, 8'd3, 8'd4};
    w_mem  = '{8'd1, 8'd1, 8'd1, 8'd1,
               8'd2, 8'd0, 8'hFF, 8'd1,
               8'd0, 8'd3, 8'd0, 8'd0,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};
    b_mem  = '{8'd0, 8'd5, 8'hFF, 8'd10};
    clearLogs();
    applyStimulus(-1, -1, -1, 100, edges);
    idleCycle();
    checkOutput("mix_done_edge", edges, 28);
    checkWrites("mix", 4, exp_mix);

    $display("[TB] start re-pulsed while busy");
    loadUniform(8'd1, 8'd2, 8'd0);
    clearLogs();
    applyStimulus(5, 27, -1, 100, edges);
    idleCycle();
    checkOutput("repulse_done_edge", edges, 28);
    checkOutput("repulse_done_pulses", done_cnt, 1);
    checkWrites("repulse", 4, exp_ones);
    clearLogs();
    applyStimulus(-1, -1, -1, 100, edges);
    idleCycle();
    checkOutput("rerun_done_edge", edges, 28);
    checkWrites("rerun", 4, exp_ones);

    $display("[TB] start and abort together in idle");
    start = 1'b1;
    abort = 1'b1;
    idleCycle();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("startabort_busy", int'(busy), 0);

    $display("[TB] abort in write of output 1");
    clearLogs();
    applyStimulus(-1, -1, 13, 14, edges);
    checkOutput("abort_busy_next", int'(busy), 0);
    checkOutput("abort_trigger_next", int'(trigger), 0);
    repeat (3) idleCycle();
    checkOutput("abort_no_done", done_cnt, 0);
    checkWrites("abort", 1, exp_ones);

    $display("[TB] reset during MAC of output 2");
    clearLogs();
    applyStimulus(-1, -1, -1, 16, edges);
    #2;
    rst = 1'b1;
    #1;
    checkIdleOutputs("midrst");
    repeat (2) @(posedge usb_clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_no_done", done_cnt, 0);
    checkWrites("midrst", 2, exp_ones);
    idleCycle();
    clearLogs();
    applyStimulus(-1, -1, -1, 100, edges);
    idleCycle();
    checkOutput("postrst_done_edge", edges, 28);
    checkWrites("postrst", 4, exp_ones);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
